// File: rtl/qspi_pkg.sv
// Shared definitions for the quad-SPI register-write responder: FSM encoding,
// highest legal register address and the per-register payload length table.
package qspi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [4:0] REG_ADDR_MAX = 5'h18;

    // Payload bytes for a write to addr; anything past REG_ADDR_MAX is a 4-byte register.
    function automatic logic [2:0] reg_len(input logic [4:0] addr);
        case (addr)
            5'h00:               return 3'd1;
            5'h01, 5'h03, 5'h06: return 3'd3;
            5'h02, 5'h05, 5'h07: return 3'd2;
            default:             return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/quad_spi_responder_if.sv
// Pin and register-port bundle of quad_spi_responder; master drives the serial
// pins, slave (the responder) drives the decoded register events.
interface quad_spi_responder_if;

    logic        cs;
    logic        sclk;
    logic [3:0]  sdio;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [4:0]  rd_addr;
    logic        frame_err;
    logic        busy;

    modport master (
        output cs, sclk, sdio,
        input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, frame_err, busy
    );

    modport slave (
        input  cs, sclk, sdio,
        output wr_valid, wr_addr, wr_data, rd_req, rd_addr, frame_err, busy
    );

endinterface

// File: rtl/qspi_sync.sv
// Multi-flop synchronizer for a bundle of asynchronous inputs; every bit gets
// DEPTH flops and resets to its own bit of RESET_VAL.
module qspi_sync #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: state flops use <= only, so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_q <= {DEPTH{RESET_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/quad_spi_responder.sv
// Quad-SPI responder: decodes instruction bytes into register writes / read requests.
// Build option: QSPI_RESP_ADDR_CHECK_EN rejects instruction addresses above REG_ADDR_MAX.
module quad_spi_responder
    import qspi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    quad_spi_responder_if.slave  bus
);

    logic       cs_s, sclk_s;
    logic [3:0] sdio_s;

    // Idle pin levels (cs=1, sclk=1) come out of reset so no false edge is seen.
    qspi_sync #(
        .WIDTH    (6),
        .DEPTH    (SYNC_STAGES),
        .RESET_VAL(6'b11_0000)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    ({bus.cs, bus.sclk, bus.sdio}),
        .q    ({cs_s, sclk_s, sdio_s})
    );

    state_t      state_q, state_d;
    logic        cs_prev_q, cs_prev_d;
    logic        sclk_prev_q, sclk_prev_d;
    logic        half_q, half_d;
    logic [3:0]  hi_nib_q, hi_nib_d;
    logic [4:0]  cur_addr_q, cur_addr_d;
    logic [2:0]  bytes_left_q, bytes_left_d;
    logic [31:0] data_q, data_d;
    logic        wr_valid_q, wr_valid_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        rd_req_q, rd_req_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        frame_err_q, frame_err_d;

    logic        cs_fall, cs_rise, capture, addr_illegal;
    logic [4:0]  instr_addr;
    logic [7:0]  rx_byte;

    assign cs_fall    = ~cs_s & cs_prev_q;
    assign cs_rise    = cs_s & ~cs_prev_q;
    assign capture    = sclk_s & ~sclk_prev_q & ~cs_s;
    assign rx_byte    = {hi_nib_q, sdio_s};
    assign instr_addr = rx_byte[4:0];

`ifdef QSPI_RESP_ADDR_CHECK_EN
    assign addr_illegal = (instr_addr > REG_ADDR_MAX);
`else
    assign addr_illegal = 1'b0;
`endif

    // NOTE: every signal assigned here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cs_prev_d    = cs_s;
        sclk_prev_d  = sclk_s;
        half_d       = half_q;
        hi_nib_d     = hi_nib_q;
        cur_addr_d   = cur_addr_q;
        bytes_left_d = bytes_left_q;
        data_d       = data_q;
        wr_valid_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_req_d     = 1'b0;
        rd_addr_d    = rd_addr_q;
        frame_err_d  = 1'b0;

        if (cs_rise) begin
            // A frame is only lost when it stops mid-byte or mid-payload.
            frame_err_d = ((state_q == INSTR) && half_q) || (state_q == DATA);
            state_d     = IDLE;
            half_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = INSTR;
                        half_d  = 1'b0;
                    end
                end
                INSTR: begin
                    if (capture && !half_q) begin
                        hi_nib_d = sdio_s;
                        half_d   = 1'b1;
                    end else if (capture) begin
                        half_d     = 1'b0;
                        cur_addr_d = instr_addr;
                        if (addr_illegal) begin
                            frame_err_d = 1'b1;
                            state_d     = DRAIN;
                        end else if (rx_byte[7]) begin
                            rd_req_d  = 1'b1;
                            rd_addr_d = instr_addr;
                            state_d   = DRAIN;
                        end else begin
                            bytes_left_d = reg_len(instr_addr);
                            data_d       = '0;
                            state_d      = DATA;
                        end
                    end
                end
                DATA: begin
                    if (capture && !half_q) begin
                        hi_nib_d = sdio_s;
                        half_d   = 1'b1;
                    end else if (capture) begin
                        half_d       = 1'b0;
                        data_d       = {data_q[23:0], rx_byte};
                        bytes_left_d = bytes_left_q - 3'd1;
                        if (bytes_left_q == 3'd1) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = cur_addr_q;
                            wr_data_d  = data_d;
                            state_d    = INSTR;
                        end
                    end
                end
                DRAIN: begin
                    state_d = DRAIN;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cs_prev_q    <= 1'b1;
            sclk_prev_q  <= 1'b1;
            half_q       <= 1'b0;
            hi_nib_q     <= '0;
            cur_addr_q   <= '0;
            bytes_left_q <= '0;
            data_q       <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_prev_q    <= cs_prev_d;
            sclk_prev_q  <= sclk_prev_d;
            half_q       <= half_d;
            hi_nib_q     <= hi_nib_d;
            cur_addr_q   <= cur_addr_d;
            bytes_left_q <= bytes_left_d;
            data_q       <= data_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_req    = rd_req_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_quad_spi_responder.sv
// Self-checking bench for quad_spi_responder: table of whole frames plus directed
// sequences for latency, output hold and mid-frame reset.
module tb_quad_spi_responder;

    localparam int SYNC_STAGES = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    quad_spi_responder_if bus();

    quad_spi_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    // Pulse monitor: logs every event, sampled on the falling clock edge.
    int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
    logic [4:0]  wr_log_addr [0:127];
    logic [31:0] wr_log_data [0:127];

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.wr_valid) begin
                wr_log_addr[wr_cnt] = bus.wr_addr;
                wr_log_data[wr_cnt] = bus.wr_data;
                wr_cnt++;
            end
            if (bus.rd_req)    rd_cnt++;
            if (bus.frame_err) err_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_nibble(input logic [3:0] nib);
        @(negedge clock);
        bus.sclk = 1'b0;
        bus.sdio = nib;
        wait_clk(4);
        bus.sclk = 1'b1;
        wait_clk(3);
    endtask

    task automatic send_frame(input int n, input logic [63:0] nibs);
        @(negedge clock);
        bus.cs = 1'b0;
        wait_clk(4);
        for (int i = 0; i < n; i++) begin
            send_nibble(nibs[4*(n-1-i) +: 4]);
        end
        wait_clk(4);
        bus.cs = 1'b1;
        wait_clk(12);
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [63:0] nibs;
        int          exp_wr;
        logic [4:0]  exp_first_addr;
        logic [31:0] exp_first_data;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        int          exp_rd;
        logic [4:0]  exp_rd_addr;
        int          exp_err;
    } vec_t;

    vec_t vecs [0:13];

    initial begin
        int wr0, rd0, err0, lat;
        logic seen;

        vecs[0]  = '{"wr04_deadbeef", 10, 64'h04DEADBEEF, 1, 5'h04, 32'hDEADBEEF, 5'h04, 32'hDEADBEEF, 0, 5'h00, 0};
        vecs[1]  = '{"wr00_f0",        4, 64'h00F0,       1, 5'h00, 32'h000000F0, 5'h00, 32'h000000F0, 0, 5'h00, 0};
        vecs[2]  = '{"stream_00_05",  10, 64'h00F0051234, 2, 5'h00, 32'h000000F0, 5'h05, 32'h00001234, 0, 5'h00, 0};
        vecs[3]  = '{"rd83_dummy",     8, 64'h83000000,   0, 5'h00, 32'h0,        5'h00, 32'h0,        1, 5'h03, 0};
        vecs[4]  = '{"abort_in_data",  5, 64'h01ABC,      0, 5'h00, 32'h0,        5'h00, 32'h0,        0, 5'h00, 1};
`ifdef QSPI_RESP_ADDR_CHECK_EN
        vecs[5]  = '{"wr1f",          10, 64'h1F11223344, 0, 5'h00, 32'h0,        5'h00, 32'h0,        0, 5'h00, 1};
        vecs[12] = '{"rd9f",           2, 64'h9F,         0, 5'h00, 32'h0,        5'h00, 32'h0,        0, 5'h00, 1};
`else
        vecs[5]  = '{"wr1f",          10, 64'h1F11223344, 1, 5'h1F, 32'h11223344, 5'h1F, 32'h11223344, 0, 5'h00, 0};
        vecs[12] = '{"rd9f",           2, 64'h9F,         0, 5'h00, 32'h0,        5'h00, 32'h0,        1, 5'h1F, 0};
`endif
        vecs[6]  = '{"odd_instr",      1, 64'h0,          0, 5'h00, 32'h0,        5'h00, 32'h0,        0, 5'h00, 1};
        vecs[7]  = '{"empty_data",     2, 64'h02,         0, 5'h00, 32'h0,        5'h00, 32'h0,        0, 5'h00, 1};
        vecs[8]  = '{"wr07",           6, 64'h07C35A,     1, 5'h07, 32'h0000C35A, 5'h07, 32'h0000C35A, 0, 5'h00, 0};
        vecs[9]  = '{"wr06",           8, 64'h06123456,   1, 5'h06, 32'h00123456, 5'h06, 32'h00123456, 0, 5'h00, 0};
        vecs[10] = '{"wr64_ignbits",  10, 64'h6412345678, 1, 5'h04, 32'h12345678, 5'h04, 32'h12345678, 0, 5'h00, 0};
        vecs[11] = '{"wr18",          10, 64'h1801020304, 1, 5'h18, 32'h01020304, 5'h18, 32'h01020304, 0, 5'h00, 0};
        vecs[13] = '{"wr03_then_rd85",10, 64'h03AABBCC85, 1, 5'h03, 32'h00AABBCC, 5'h03, 32'h00AABBCC, 1, 5'h05, 0};

        bus.cs   = 1'b1;
        bus.sclk = 1'b1;
        bus.sdio = 4'h0;

        // Reset state
        wait_clk(3);
        check("rst_wr_valid",  {31'b0, bus.wr_valid},  32'h0);
        check("rst_rd_req",    {31'b0, bus.rd_req},    32'h0);
        check("rst_frame_err", {31'b0, bus.frame_err}, 32'h0);
        check("rst_busy",      {31'b0, bus.busy},      32'h0);
        check("rst_wr_addr",   {27'b0, bus.wr_addr},   32'h0);
        check("rst_wr_data",   bus.wr_data,            32'h0);
        check("rst_rd_addr",   {27'b0, bus.rd_addr},   32'h0);
        reset = 1'b0;
        wait_clk(5);

        // Table of complete frames
        for (int v = 0; v < 14; v++) begin
            wr0  = wr_cnt;
            rd0  = rd_cnt;
            err0 = err_cnt;
            send_frame(vecs[v].n, vecs[v].nibs);
            check({vecs[v].name, "_wr_cnt"},  wr_cnt - wr0,   vecs[v].exp_wr);
            check({vecs[v].name, "_rd_cnt"},  rd_cnt - rd0,   vecs[v].exp_rd);
            check({vecs[v].name, "_err_cnt"}, err_cnt - err0, vecs[v].exp_err);
            check({vecs[v].name, "_busy"},    {31'b0, bus.busy}, 32'h0);
            if (vecs[v].exp_wr > 0 && wr_cnt > wr0) begin
                check({vecs[v].name, "_first_addr"}, {27'b0, wr_log_addr[wr0]}, {27'b0, vecs[v].exp_first_addr});
                check({vecs[v].name, "_first_data"}, wr_log_data[wr0], vecs[v].exp_first_data);
                check({vecs[v].name, "_last_addr"},  {27'b0, wr_log_addr[wr_cnt-1]}, {27'b0, vecs[v].exp_addr});
                check({vecs[v].name, "_last_data"},  wr_log_data[wr_cnt-1], vecs[v].exp_data);
            end
            if (vecs[v].exp_rd > 0) begin
                check({vecs[v].name, "_rd_addr"}, {27'b0, bus.rd_addr}, {27'b0, vecs[v].exp_rd_addr});
            end
        end

        // Latency from the final pin-level SCLK rise to wr_valid, write 0x00 + 0x3C
        @(negedge clock);
        bus.cs = 1'b0;
        wait_clk(4);
        send_nibble(4'h0);
        send_nibble(4'h0);
        send_nibble(4'h3);
        check("busy_mid_frame", {31'b0, bus.busy}, 32'h1);
        @(negedge clock);
        bus.sclk = 1'b0;
        bus.sdio = 4'hC;
        wait_clk(4);
        bus.sclk = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clock);
            lat++;
            seen = bus.wr_valid;
        end
        check("lat_wr_valid_seen", {31'b0, seen}, 32'h1);
        check("lat_within_bound", {31'b0, (lat <= SYNC_STAGES + 2)}, 32'h1);
        check("lat_wr_data", bus.wr_data, 32'h0000003C);
        @(negedge clock);
        check("wr_valid_one_cycle", {31'b0, bus.wr_valid}, 32'h0);
        wait_clk(4);
        bus.cs = 1'b1;
        wait_clk(12);

        // Write outputs hold across a later read frame
        send_frame(8, 64'h8A000000);
        check("hold_wr_addr", {27'b0, bus.wr_addr}, 32'h0);
        check("hold_wr_data", bus.wr_data, 32'h0000003C);
        check("hold_rd_addr", {27'b0, bus.rd_addr}, 32'h0A);

        // Reset in the middle of a DATA nibble, then a clean write 0x02 + 0xABCD
        @(negedge clock);
        bus.cs = 1'b0;
        wait_clk(4);
        send_nibble(4'h0);
        send_nibble(4'h2);
        send_nibble(4'hA);
        @(negedge clock);
        bus.sclk = 1'b0;
        bus.sdio = 4'hB;
        wait_clk(2);
        reset = 1'b1;
        #1;
        check("midrst_wr_data", bus.wr_data, 32'h0);
        check("midrst_wr_addr", {27'b0, bus.wr_addr}, 32'h0);
        check("midrst_rd_addr", {27'b0, bus.rd_addr}, 32'h0);
        check("midrst_busy",    {31'b0, bus.busy},    32'h0);
        wait_clk(3);
        bus.cs   = 1'b1;
        bus.sclk = 1'b1;
        wait_clk(2);
        wr0  = wr_cnt;
        err0 = err_cnt;
        reset = 1'b0;
        wait_clk(10);
        check("postrst_no_wr",  wr_cnt - wr0,     32'h0);
        check("postrst_no_err", err_cnt - err0,   32'h0);
        check("postrst_busy",   {31'b0, bus.busy}, 32'h0);
        send_frame(6, 64'h02ABCD);
        check("postrst_wr_cnt",  wr_cnt - wr0,   32'h1);
        check("postrst_err_cnt", err_cnt - err0, 32'h0);
        check("postrst_wr_addr", {27'b0, bus.wr_addr}, 32'h02);
        check("postrst_wr_data", bus.wr_data, 32'h0000ABCD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/quad_spi_responder.md
QUAD_SPI_RESPONDER -- requirements
Module: quad_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on cs/sclk/sdio (legal range 2..4).
REQ-002 SHALL have ports: clock  in  1  system clock, at least 4x the SCLK rate.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: cs  in  1  chip select, active low.
REQ-005 SHALL have ports: sclk  in  1  serial clock, idle high; data changes on falling edge.
REQ-006 SHALL have ports: sdio  in  4  serial data nibble, MSB nibble first.
REQ-007 SHALL have ports: wr_valid  out  1  one-cycle pulse; a complete register write is available.
REQ-008 SHALL have ports: wr_addr  out  5  address of the written register.
REQ-009 SHALL have ports: wr_data  out  32  write payload, right-aligned, upper bytes zero.
REQ-010 SHALL have ports: rd_req  out  1  one-cycle pulse; a read instruction was decoded.
REQ-011 SHALL have ports: rd_addr  out  5  address of the read request.
REQ-012 SHALL have ports: frame_err  out  1  one-cycle pulse; the frame was aborted or illegal.
REQ-013 SHALL have ports: busy  out  1  high while a frame is in progress (state is not IDLE).

Function
REQ-014 SHALL pass cs, sclk and sdio through SYNC_STAGES flops and act only on synchronized values.
REQ-015 SHALL capture one nibble per synchronized sclk rising edge while synchronized cs is low.
REQ-016 SHALL assemble bytes from two nibbles, high nibble first.
REQ-017 SHALL use FSM states IDLE, INSTR, DATA and DRAIN.
REQ-018 SHALL treat the first byte after cs falls as the instruction: bit7 = read (1) / write (0), bits4:0 = address, bits6:5 ignored.
REQ-019 SHALL take write payload length from the register length table: 0x00=1; 0x01, 0x03, 0x06=3; 0x02, 0x05, 0x07=2; 0x04, 0x08..0x18=4 bytes.
REQ-020 SHALL shift payload bytes MSB-first and, on the final nibble, pulse wr_valid exactly one clock after that nibble's capture cycle.
REQ-021 SHALL hold wr_addr/wr_data stable until the next wr_valid.
REQ-022 SHALL, on a read instruction, pulse rd_req one clock after the instruction's second nibble, then enter DRAIN and ignore nibbles until cs rises.
REQ-023 SHALL, when nibbles continue after a completed write with cs still low, return to INSTR and decode the next byte as a new instruction (streamed transactions).
REQ-024 SHALL, when cs rises in INSTR after an odd nibble or anywhere in DATA, discard the partial frame, pulse frame_err once, and go to IDLE.
REQ-025 SHALL, when cs rises in INSTR at a byte boundary, in DRAIN, or in IDLE, return to IDLE without frame_err.
REQ-026 SHALL give the cs-rise abort priority over a simultaneous sclk capture in the same cycle.
REQ-027 SHALL produce worst-case latency from the pin-level SCLK rise to wr_valid of SYNC_STAGES+2 clocks.

Reset
REQ-028 SHALL, when reset is asserted, immediately drive wr_valid=0, rd_req=0, frame_err=0, busy=0, wr_addr=0, wr_data=0 and rd_addr=0, set FSM=IDLE, and set synchronizers to cs=1, sclk=1, sdio=0.
REQ-029 SHALL, when reset is asserted mid-frame, drop the frame silently; after release, no capture occurs until a fresh cs falling edge.

Configuration
REQ-030 SHALL, with QSPI_RESP_ADDR_CHECK_EN defined, treat an instruction address >0x18 as illegal: pulse frame_err with the rd_req timing, enter DRAIN, and produce no wr_valid/rd_req.
REQ-031 SHALL, without QSPI_RESP_ADDR_CHECK_EN, accept addresses 0x19..0x1F as 4-byte registers.

Structure
REQ-032 SHALL place the state encoding, the REG_ADDR_MAX=0x18 constant and the address-to-length function in shared package qspi_pkg.
REQ-033 SHALL implement the synchronizer as sub-module qspi_sync (parameterized width and depth).

Verification
REQ-034 SHALL cover: write 0x04 + DEADBEEF (10 nibbles) -> one wr_valid, wr_addr=0x04, wr_data=0xDEADBEEF.
REQ-035 SHALL cover: write 0x00 + 0xF0 -> wr_data=0x000000F0; then write 0x05 + 0x1234 streamed in the same cs-low period -> second wr_valid with wr_addr=0x05, wr_data=0x00001234.
REQ-036 SHALL cover: instruction 0x83 then 6 dummy nibbles -> rd_req with rd_addr=0x03, no wr_valid, no frame_err.
REQ-037 SHALL cover: write 0x01 with cs rising after 3 payload nibbles -> frame_err once, no wr_valid, busy=0 afterwards.
REQ-038 SHALL cover: instruction 0x1F -> frame_err only with QSPI_RESP_ADDR_CHECK_EN, else a 4-byte write to 0x1F.
REQ-039 SHALL cover: reset asserted in the middle of a DATA nibble, then a full write 0x02 + 0xABCD -> wr_data=0x0000ABCD with no stale bytes.
